// File: rtl/ds_tx_pkg.sv
// Shared definitions for the differential-buffer transmit serializer.
//   ds_state_e : framing FSM states (idle, lead-in, data shift, tail-out)
//   cnt_width  : width of the cycle/bit counter, sized so that the counter
//                never wraps within any state
package ds_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLead  = 2'd1,
    StShift = 2'd2,
    StTail  = 2'd3
  } ds_state_e;

  // $clog2(max(data_w, lead, tail, 1) + 1)
  function automatic int unsigned cnt_width(input int unsigned data_w,
                                            input int unsigned lead,
                                            input int unsigned tail);
    int unsigned m;
    m = 1;
    if (data_w > m) m = data_w;
    if (lead > m) m = lead;
    if (tail > m) m = tail;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ds_tx_shreg.sv
// Loadable shift register feeding the serializer's data bit.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset, clears the register
//   load_i      : load data_i (wins over shift_i)
//   shift_i     : advance one bit toward the output end
//   data_i      : parallel word to load
//   head_next_o : bit that will sit at the output end after this edge;
//                 lets the parent register tx_i with no extra cycle of latency
module ds_tx_shreg #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              head_next_o
);

  logic [DATA_W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST != 0) shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      else                shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
    end
    head_next_o = (MSB_FIRST != 0) ? shreg_d[DATA_W-1] : shreg_d[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

endmodule

// File: rtl/ds_tx_serializer.sv
// Serializer in front of a tristate differential output buffer. Words arrive
// over valid/ready and leave one bit per clock on tx_i, framed by LEAD_CYCLES
// and TAIL_CYCLES of driven-low pad so the bus turns around cleanly.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_data    : word to transmit, sampled on acceptance
//   in_valid   : in_data valid
//   in_ready   : word can be accepted this cycle (combinational from state)
//   tx_i       : serial data to the buffer I pin (registered)
//   tx_oe      : output enable to the buffer OE pin (registered)
//   busy       : FSM not idle
//   frame_done : one-cycle pulse on the first idle cycle after a burst
module ds_tx_serializer
  import ds_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LEAD_CYCLES = 2,
  parameter int unsigned TAIL_CYCLES = 2,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_i,
  output logic              tx_oe,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CntW = cnt_width(DATA_W, LEAD_CYCLES, TAIL_CYCLES);
  localparam logic [CntW-1:0] LastBit  = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] LastLead = CntW'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);
  localparam logic [CntW-1:0] LastTail = CntW'((TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0);

  ds_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            tx_i_q, tx_oe_q, frame_done_q;
  logic            accept;
  logic            head_next;

  // Ready on the last data bit as well, so back-to-back words stream
  // without lead/tail in between.
  assign in_ready = (state_q == StIdle) || ((state_q == StShift) && (cnt_q == LastBit));
  assign accept   = in_valid && in_ready;

  ds_tx_shreg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (accept),
    .shift_i     (state_q == StShift),
    .data_i      (in_data),
    .head_next_o (head_next)
  );

  // Outputs are registered from the next state, so the first lead (or data)
  // cycle appears the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tx_i_q       <= 1'b0;
      tx_oe_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q   <= '0;
            tx_oe_q <= 1'b1;
            if (LEAD_CYCLES > 0) begin
              state_q <= StLead;
              tx_i_q  <= 1'b0;
            end else begin
              state_q <= StShift;
              tx_i_q  <= head_next;
            end
          end
        end
        StLead: begin
          if (cnt_q == LastLead) begin
            state_q <= StShift;
            cnt_q   <= '0;
            tx_i_q  <= head_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (cnt_q == LastBit) begin
            cnt_q <= '0;
            if (accept) begin
              tx_i_q <= head_next;
            end else if (TAIL_CYCLES > 0) begin
              state_q <= StTail;
              tx_i_q  <= 1'b0;
            end else begin
              state_q      <= StIdle;
              tx_i_q       <= 1'b0;
              tx_oe_q      <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            tx_i_q <= head_next;
          end
        end
        StTail: begin
          if (cnt_q == LastTail) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tx_oe_q      <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign tx_i       = tx_i_q;
  assign tx_oe      = tx_oe_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ds_tx_serializer.sv
module tb_ds_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       va = 1'b0, vb = 1'b0;
  logic       a_rdy, a_ti, a_oe, a_busy, a_done;
  logic       b_rdy, b_ti, b_oe, b_busy, b_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // A: DATA_W=8, LEAD=2, TAIL=2, MSB first
  ds_tx_serializer #(
    .DATA_W (8), .LEAD_CYCLES (2), .TAIL_CYCLES (2), .MSB_FIRST (1)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (va),
    .in_ready   (a_rdy),
    .tx_i       (a_ti),
    .tx_oe      (a_oe),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  // B: DATA_W=8, LEAD=0, TAIL=0, LSB first
  ds_tx_serializer #(
    .DATA_W (8), .LEAD_CYCLES (0), .TAIL_CYCLES (0), .MSB_FIRST (0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (vb),
    .in_ready   (b_rdy),
    .tx_i       (b_ti),
    .tx_oe      (b_oe),
    .busy       (b_busy),
    .frame_done (b_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One character per cycle in each string; cycle 0 is the first string index.
  task automatic run(input bit sel, input string tag, input logic [7:0] d0,
                     input logic [7:0] d1, input string val, input string rs,
                     input string oe, input string ti, input string rdy,
                     input string dn);
    for (int c = 0; c < val.len(); c++) begin
      rst     = (rs[c] == "1");
      in_data = (c == 0) ? d0 : d1;
      if (sel) vb = (val[c] == "1");
      else     va = (val[c] == "1");
      chk($sformatf("%s c%0d tx_oe", tag, c),    sel ? b_oe   : a_oe,   oe[c] == "1");
      chk($sformatf("%s c%0d busy", tag, c),     sel ? b_busy : a_busy, oe[c] == "1");
      chk($sformatf("%s c%0d tx_i", tag, c),     sel ? b_ti   : a_ti,   ti[c] == "1");
      chk($sformatf("%s c%0d in_ready", tag, c), sel ? b_rdy  : a_rdy,  rdy[c] == "1");
      chk($sformatf("%s c%0d frame_done", tag, c), sel ? b_done : a_done, dn[c] == "1");
      step();
    end
    va  = 1'b0;
    vb  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain(input bit sel, input string tag);
    for (int i = 0; i < 60 && (sel ? b_busy : a_busy); i++) step();
    chk({tag, " drain busy"}, sel ? b_busy : a_busy, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk("reset a tx_oe", a_oe, 1'b0);
    chk("reset a tx_i", a_ti, 1'b0);
    chk("reset a busy", a_busy, 1'b0);
    chk("reset a frame_done", a_done, 1'b0);
    chk("reset a in_ready", a_rdy, 1'b1);
    chk("reset b tx_oe", b_oe, 1'b0);
    chk("reset b busy", b_busy, 1'b0);
    rst = 1'b0;
    step();

    // Single word 0xA5
    run(1'b0, "single", 8'hA5, 8'h00,
        "10000000000000", "00000000000000",
        "01111111111110", "00010100101000",
        "10000000001001", "00000000000001");

    // 0xA5 then 0x3C streamed, accepted at cycle 10
    run(1'b0, "stream", 8'hA5, 8'h3C,
        "1111111111100000000000", "0000000000000000000000",
        "0111111111111111111110", "0001010010100111100000",
        "1000000000100000001001", "0000000000000000000001");

    // Valid held in lead and tail is ignored; next accept at cycle 13
    run(1'b0, "hold", 8'hA5, 8'h5A,
        "111000000001110", "000000000000000",
        "011111111111101", "000101001010000",
        "100000000010010", "000000000000010");
    drain(1'b0, "hold");

    // Reset mid-shift at cycle 6, new word 0xFF at cycle 8
    run(1'b0, "midrst", 8'hA5, 8'hFF,
        "10000000100", "00000010000",
        "01111110011", "00010100000",
        "10000001100", "00000000000");
    drain(1'b0, "midrst");

    // No lead/tail, LSB first, word 0x01
    run(1'b1, "lsb01", 8'h01, 8'h00,
        "1000000000", "0000000000",
        "0111111110", "0100000000",
        "1000000011", "0000000001");

    // No lead/tail, LSB first, 0xB4 then 0x81 streamed
    run(1'b1, "lsbstream", 8'hB4, 8'h81,
        "111111111000000000", "000000000000000000",
        "011111111111111110", "000101101100000010",
        "100000001000000011", "000000000000000001");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
